// File: rtl/milano_pkg.sv
// Shared types and constants for the milano instruction-fetch front end.
package milano_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    // One buffered fetch result: the PC it was fetched from and the word returned.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] rdata;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both as the fetch buffer and as the queue of granted PCs.
// A push into a full FIFO is accepted when a pop happens in the same cycle; flush wins over push.
module fetch_fifo
    import milano_pkg::*;
#(
    parameter type data_t = fetch_entry_t,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             push,
    input  data_t            wdata,
    input  logic             pop,
    output data_t            rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    data_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy bookkeeping; reset and flush both return to empty.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, req/gnt/rvalid handshake to instruction
// memory, buffering of {addr, instr} pairs and redirect handling with in-flight discard.
module if_fetch_unit
    import milano_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] instr_addr_id_o,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      pc_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] discard_q;
    fetch_state_e     state_q;
    fetch_state_e     state_d;

    logic             credit_ok;
    logic [CNT_W:0]   inflight;
    logic             grant;
    logic             resp_ok;
    logic             resp_keep;

    logic [31:0]      aq_head;
    logic             aq_full;
    logic             aq_empty;
    logic [CNT_W-1:0] aq_count;

    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             data_full;
    logic             data_empty;
    logic             data_pop;
    logic [CNT_W-1:0] data_count;

    // Words in flight plus words buffered must never exceed the buffer size,
    // so every response is guaranteed a slot when it arrives.
    assign inflight  = {1'b0, outstanding_q} + {1'b0, data_count};
    assign credit_ok = inflight < (CNT_W + 1)'(FIFO_DEPTH);

    assign instr_req_o  = fetch_en_i & credit_ok & ~branch_i;
    assign instr_addr_o = pc_q;
    assign grant        = instr_req_o & instr_gnt_i;

    // A response only counts if something is outstanding; those still owed to a
    // pre-redirect path are dropped, as is anything landing in the redirect cycle.
    assign resp_ok   = instr_rvalid_i & (outstanding_q != '0);
    assign resp_keep = resp_ok & (discard_q == '0) & ~branch_i;

    assign push_entry = '{addr: aq_head, rdata: instr_rdata_i};
    assign data_pop   = ~data_empty & id_ready_i & ~branch_i;

    assign instr_valid_o    = ~data_empty;
    assign instr_rdata_id_o = data_empty ? '0 : head_entry.rdata;
    assign instr_addr_id_o  = data_empty ? '0 : head_entry.addr;
    assign busy_o           = (outstanding_q != '0) | (data_count != '0);

    fetch_fifo #(
        .data_t (logic [31:0]),
        .DEPTH  (FIFO_DEPTH)
    ) u_addr_queue (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (branch_i),
        .push  (grant),
        .wdata (pc_q),
        .pop   (resp_keep),
        .rdata (aq_head),
        .full  (aq_full),
        .empty (aq_empty),
        .count (aq_count)
    );

    fetch_fifo #(
        .data_t (fetch_entry_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_instr_buffer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (branch_i),
        .push  (resp_keep),
        .wdata (push_entry),
        .pop   (data_pop),
        .rdata (head_entry),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    // PC advance on grant, redirect on branch, and in-flight/discard accounting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            if (branch_i) begin
                pc_q      <= branch_target_i & 32'hFFFF_FFFC;
                discard_q <= outstanding_q - CNT_W'(resp_ok);
            end else begin
                if (grant) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (resp_ok && (discard_q != '0)) begin
                    discard_q <= discard_q - CNT_W'(1);
                end
            end
            outstanding_q <= outstanding_q + CNT_W'(grant) - CNT_W'(resp_ok);
        end
    end

    // Status state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status next-state: leaving RUN with work in flight passes through DRAIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!fetch_en_i) begin
                    state_d = busy_o ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (fetch_en_i) begin
                    state_d = RUN;
                end else if (!busy_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> (outstanding_q != '0));

    a_addr_queue_tracks: assert property (@(posedge clk_i) disable iff (rst_i)
        aq_count == (outstanding_q - discard_q));

    a_kept_resp_has_addr: assert property (@(posedge clk_i) disable iff (rst_i)
        resp_keep |-> !aq_empty);

    a_no_req_when_buf_full: assert property (@(posedge clk_i) disable iff (rst_i)
        data_full |-> !instr_req_o);

    a_no_req_when_aq_full: assert property (@(posedge clk_i) disable iff (rst_i)
        aq_full |-> !instr_req_o);

    a_no_branch_with_grant: assert property (@(posedge clk_i) disable iff (rst_i)
        !(branch_i && grant));

    a_idle_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == IDLE) |-> !busy_o);

endmodule
